// File: rtl/uop_pkg.sv
// rtl/uop_pkg.sv - uop encoding types, unpack formats and decode helpers
package uop_pkg;

    typedef enum logic [4:0] {
        UOP_ADD       = 5'd0,
        UOP_SUB       = 5'd1,
        UOP_AND       = 5'd2,
        UOP_ORR       = 5'd3,
        UOP_XOR       = 5'd4,
        UOP_EOR       = 5'd5,
        UOP_MVN       = 5'd6,
        UOP_ASR       = 5'd7,
        UOP_FMOV      = 5'd8,
        UOP_FNEG      = 5'd9,
        UOP_FADD      = 5'd10,
        UOP_FMUL      = 5'd11,
        UOP_FSUB      = 5'd12,
        UOP_LOAD      = 5'd13,
        UOP_STORE     = 5'd14,
        UOP_UBFM      = 5'd15,
        UOP_MOVZ      = 5'd16,
        UOP_MOVK      = 5'd17,
        UOP_ADRP_MOV  = 5'd18,
        UOP_BCOND     = 5'd19,
        UOP_BL        = 5'd20,
        UOP_CHECK_RET = 5'd21,
        UOP_HLT       = 5'd22
    } uop_code;

    typedef struct packed {
        logic       is_fp;
        logic [4:0] gpr;
    } uop_reg;

    typedef struct packed {
        uop_reg dst;
        uop_reg src1;
        uop_reg src2;
        logic   set_nzcv;
    } uop_rr;

    typedef struct packed {
        uop_reg      dst;
        uop_reg      src;
        logic [20:0] imm;
        logic [1:0]  hw;
        logic        set_nzcv;
    } uop_ri;

    typedef struct packed {
        logic [63:0] target;
        logic [3:0]  cond;
        logic        predict_taken;
    } uop_branch;

    localparam int UOP_RR_W   = $bits(uop_rr);
    localparam int UOP_RI_W   = $bits(uop_ri);
    localparam int UOP_DATA_W = $bits(uop_branch);

    typedef struct packed {
        uop_code                 uopcode;
        logic                    valb_sel;
        logic                    mem_read;
        logic                    mem_write;
        logic                    w_enable;
        logic                    tx_begin;
        logic                    tx_end;
        logic [63:0]             pc;
        logic [UOP_DATA_W-1:0]   data;
    } uop_insn;

    typedef enum logic [1:0] {FMT_NONE, FMT_RR, FMT_RI, FMT_BR} uop_fmt_e;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} unpack_state_e;

    // The union-style data field is shared; each view reads from bit 0 upward.
    function automatic uop_rr get_data_rr(input logic [UOP_DATA_W-1:0] data);
        return uop_rr'(data[UOP_RR_W-1:0]);
    endfunction

    function automatic uop_ri get_data_ri(input logic [UOP_DATA_W-1:0] data);
        return uop_ri'(data[UOP_RI_W-1:0]);
    endfunction

    function automatic uop_branch get_data_br(input logic [UOP_DATA_W-1:0] data);
        return uop_branch'(data);
    endfunction

    function automatic uop_fmt_e uop_fmt_of(input uop_code code, input logic valb_sel);
        uop_fmt_e fmt;
        case (code)
            UOP_BCOND, UOP_BL, UOP_CHECK_RET:
                fmt = FMT_BR;
            UOP_LOAD, UOP_STORE, UOP_UBFM, UOP_MOVZ, UOP_MOVK, UOP_ADRP_MOV:
                fmt = FMT_RI;
            UOP_ADD, UOP_SUB, UOP_AND, UOP_ORR, UOP_XOR, UOP_EOR, UOP_MVN, UOP_ASR,
            UOP_FMOV, UOP_FNEG, UOP_FADD, UOP_FMUL, UOP_FSUB:
                fmt = valb_sel ? FMT_RI : FMT_RR;
            default:
                fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    // Wide moves place a 16-bit chunk at lane hw; everything else is a signed 21-bit offset.
    function automatic logic [63:0] uop_imm_expand(input uop_ri ri, input uop_code code);
        logic [63:0] imm;
        if (code == UOP_MOVZ || code == UOP_MOVK) begin
            imm = {48'b0, ri.imm[15:0]} << {ri.hw, 4'b0000};
        end else begin
            imm = {{43{ri.imm[20]}}, ri.imm};
        end
        return imm;
    endfunction

endpackage

// File: rtl/uop_issue_unpacker_if.sv
// rtl/uop_issue_unpacker_if.sv - uop intake and decoded-issue handshake bundle
interface uop_issue_unpacker_if;
    import uop_pkg::*;

    logic        in_valid;
    logic        in_ready;
    uop_insn     in_uop;

    logic        out_valid;
    logic        out_ready;
    uop_code     out_code;
    uop_fmt_e    out_fmt;
    uop_reg      out_dst;
    uop_reg      out_src1;
    uop_reg      out_src2;
    logic [63:0] out_imm;
    logic        out_set_nzcv;
    uop_branch   out_br;
    logic [63:0] out_pc;
    logic [5:0]  out_ctrl;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_uop, out_ready,
        output in_ready, out_valid, out_code, out_fmt, out_dst, out_src1, out_src2,
               out_imm, out_set_nzcv, out_br, out_pc, out_ctrl, out_illegal
    );

    modport master (
        output in_valid, in_uop, out_ready,
        input  in_ready, out_valid, out_code, out_fmt, out_dst, out_src1, out_src2,
               out_imm, out_set_nzcv, out_br, out_pc, out_ctrl, out_illegal
    );
endinterface

// File: rtl/uop_sync_fifo.sv
// rtl/uop_sync_fifo.sv - registered power-of-two FIFO with synchronous flush
module uop_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push;
    logic             pop;

    // No bypass: a full FIFO refuses data even while its head is leaving.
    assign wr_ready = (count != FULL_COUNT);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    // Pointer and occupancy bookkeeping; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; stale contents are harmless because rd_valid qualifies them.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uop_issue_unpacker.sv
// rtl/uop_issue_unpacker.sv - buffers packed uops, unpacks operands, sequences halt (option: UOP_UNPACK_CHECK_EN)
module uop_issue_unpacker
    import uop_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_in,
    input  logic              rst_N_in,
    input  logic              flush_in,
    output logic              halted_out,
    uop_issue_unpacker_if.slave bus
);
    unpack_state_e                state;
    unpack_state_e                state_next;
    logic                         fifo_wr_ready;
    logic                         fifo_rd_valid;
    logic [$bits(uop_insn)-1:0]   fifo_rd_data;
    uop_insn                      head;
    uop_rr                        head_rr;
    uop_ri                        head_ri;
    uop_branch                    head_br;
    uop_fmt_e                     head_fmt;
    logic                         head_illegal;
    logic                         push;
    logic                         pop;

    // Opcodes that stop intake once accepted; the checked build folds bad encodings in.
    function automatic logic is_halt_code(input uop_code code);
`ifdef UOP_UNPACK_CHECK_EN
        return code >= UOP_HLT;
`else
        return code == UOP_HLT;
`endif
    endfunction

    uop_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(uop_insn))
    ) u_fifo (
        .clk      (clk_in),
        .rst_n    (rst_N_in),
        .flush    (flush_in),
        .wr_valid (bus.in_valid && (state == ST_RUN)),
        .wr_ready (fifo_wr_ready),
        .wr_data  (bus.in_uop),
        .rd_valid (fifo_rd_valid),
        .rd_ready (bus.out_ready),
        .rd_data  (fifo_rd_data)
    );

    assign push     = bus.in_valid && bus.in_ready;
    assign pop      = fifo_rd_valid && bus.out_ready;
    assign head     = uop_insn'(fifo_rd_data);
    assign head_rr  = get_data_rr(head.data);
    assign head_ri  = get_data_ri(head.data);
    assign head_br  = get_data_br(head.data);
    assign head_fmt = uop_fmt_of(head.uopcode, head.valb_sel);

`ifdef UOP_UNPACK_CHECK_EN
    assign head_illegal = (head.uopcode > UOP_HLT);
`else
    assign head_illegal = 1'b0;
`endif

    // Halt-sequencing state register.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) state <= ST_RUN;
        else           state <= state_next;
    end

    // Next state: HLT push starts draining, HLT pop halts, flush always restarts.
    always_comb begin
        state_next = state;
        if (flush_in) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN:    if (push && is_halt_code(bus.in_uop.uopcode)) state_next = ST_DRAIN;
                ST_DRAIN:  if (pop && is_halt_code(head.uopcode))        state_next = ST_HALTED;
                ST_HALTED: state_next = ST_HALTED;
                default:   state_next = ST_RUN;
            endcase
        end
    end

    // State-derived outputs: intake only while running and not full.
    always_comb begin
        bus.in_ready = (state == ST_RUN) && fifo_wr_ready;
        halted_out   = (state == ST_HALTED);
    end

    // Head decode; every field reads zero when the FIFO is empty or the view does not use it.
    always_comb begin
        bus.out_valid    = fifo_rd_valid;
        bus.out_code     = UOP_ADD;
        bus.out_fmt      = FMT_NONE;
        bus.out_dst      = '0;
        bus.out_src1     = '0;
        bus.out_src2     = '0;
        bus.out_imm      = '0;
        bus.out_set_nzcv = 1'b0;
        bus.out_br       = '0;
        bus.out_pc       = '0;
        bus.out_ctrl     = '0;
        bus.out_illegal  = 1'b0;
        if (fifo_rd_valid) begin
            bus.out_code    = head.uopcode;
            bus.out_fmt     = head_fmt;
            bus.out_pc      = head.pc;
            bus.out_ctrl    = {head.valb_sel, head.mem_read, head.mem_write,
                               head.w_enable, head.tx_begin, head.tx_end};
            bus.out_illegal = head_illegal;
            case (head_fmt)
                FMT_RR: begin
                    bus.out_dst      = head_rr.dst;
                    bus.out_src1     = head_rr.src1;
                    bus.out_src2     = head_rr.src2;
                    bus.out_set_nzcv = head_rr.set_nzcv;
                end
                FMT_RI: begin
                    bus.out_dst      = head_ri.dst;
                    bus.out_src1     = head_ri.src;
                    bus.out_imm      = uop_imm_expand(head_ri, head.uopcode);
                    bus.out_set_nzcv = head_ri.set_nzcv;
                end
                FMT_BR: begin
                    bus.out_br = head_br;
                end
                default: begin
                    bus.out_br = '0;
                end
            endcase
        end
    end
endmodule

// File: doc/uop_issue_unpacker.md
# uop_issue_unpacker

Consumer end of the uop encoding: dequeues packed `uop_insn` words from the decode-side instruction queue and buffers them in a small FIFO. It unpacks the union-style `data` field back into RR, RI or branch form according to `uopcode`/`valb_sel`, and presents fully decoded operands to rename/issue. It also owns front-end halt sequencing: an accepted `UOP_HLT` stops intake until a flush.

## Interface
- `FIFO_DEPTH`, default 2: buffer entries; power of two, at least 2.
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_N_in`  in  1  asynchronous, active-low reset.
- `flush_in`  in  1  synchronous flush; empties the FIFO and clears halt.
- `in_valid`  in  1  upstream uop valid.
- `in_ready`  out  1  unpacker can accept this cycle.
- `in_uop`  in  `$bits(uop_insn)`  packed uop.
- `out_valid`  out  1  decoded uop at the FIFO head.
- `out_ready`  in  1  downstream accepts.
- `out_code`  out  5  `uop_code` of the head entry.
- `out_fmt`  out  2  `uop_fmt_e`: NONE/RR/RI/BR.
- `out_dst`, `out_src1`, `out_src2`  out  `$bits(uop_reg)` each  unpacked registers; zero when unused.
- `out_imm`  out  64  expanded immediate.
- `out_set_nzcv`  out  1  flag-write request.
- `out_br`  out  `$bits(uop_branch)`  branch target, condition and prediction; zero unless fmt=BR.
- `out_pc`  out  64  PC passthrough.
- `out_ctrl`  out  6  {valb_sel, mem_read, mem_write, w_enable, tx_begin, tx_end} passthrough.
- `out_illegal`  out  1  head opcode is out of range (see Configuration).
- `halted_out`  out  1  HLT retired from this stage.

## Operation
- FSM states: RUN, DRAIN, HALTED.
  - RUN → DRAIN when an entry with `uopcode==UOP_HLT` is pushed.
  - DRAIN → HALTED when that HLT entry pops (`out_valid && out_ready`).
  - `flush_in` moves any state to RUN.
- `in_ready` = (state==RUN) && !full. Push occurs on `in_valid && in_ready`.
- Format select, evaluated combinationally on the FIFO head:
  - BR: BCOND, BL, CHECK_RET.
  - RI: LOAD, STORE, UBFM, MOVZ, MOVK, ADRP_MOV, and any ALU/FP op with `valb_sel=1`.
  - RR: ADD, SUB, AND, ORR, XOR, EOR, MVN, ASR, FMOV, FNEG, FADD, FMUL, FSUB with `valb_sel=0`.
  - NONE: HLT.
- Field extraction:
  - RR: low `$bits(uop_rr)` bits of `data`.
  - RI: low `$bits(uop_ri)` bits of `data`.
  - BR: all of `data`.
  - Bits above the active view are ignored.
- Immediate expansion:
  - MOVZ/MOVK: zero-extend imm[15:0] to 64 bits, then shift left by 16*hw.
  - Other RI formats: sign-extend imm[20:0] to 64 bits.
  - RR/BR/NONE: `out_imm` = 0.
- For fmt=RI, `out_src1` = `src`. `out_src2` = 0.

## Timing
- Registered FIFO, no fall-through. A uop pushed in cycle N is first visible on `out_*` in cycle N+1.
- Throughput is one uop per cycle when not full. When full, `in_ready`=0 even if a pop happens the same cycle; there is no bypass.
- Simultaneous push and pop when not full: occupancy is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. The count register is log2(`FIFO_DEPTH`)+1 bits wide.
- `out_valid` holds, and `out_*` are stable, until the head is popped.
- Flush has priority over push and pop in the same cycle. The cycle after a flush: count=0, state=RUN, `out_valid`=0, `in_ready`=1.
- Reset values: count=0, pointers=0, state=RUN. Outputs: `out_valid`=0, `in_ready`=1, `halted_out`=0, `out_illegal`=0, all `out_*` data = 0.
- Reset asserted mid-operation discards all entries immediately (asynchronous).
- `halted_out` is registered. It rises the cycle after the HLT pop and stays high until flush or reset.
- Uops behind an HLT are never accepted, because `in_ready` drops the cycle after the HLT push.

## Configuration
- Macro `UOP_UNPACK_CHECK_EN`.
- Defined:
  - Head opcodes with encoding > `UOP_HLT` (23..31) assert `out_illegal`, get fmt=NONE, and are treated as HLT by the FSM.
  - The RUN → DRAIN transition uses the pushed opcode.
- Undefined:
  - `out_illegal` is tied to 0.
  - Out-of-range opcodes pass through as fmt=NONE with no FSM effect.

## Structure
- Add to `uop_pkg`:
  - `typedef enum logic[1:0] {FMT_NONE, FMT_RR, FMT_RI, FMT_BR} uop_fmt_e`.
  - Function `uop_fmt_of(uop_code, valb_sel)`.
  - Function `uop_imm_expand(uop_ri, uop_code)`.
- Unpacking uses the existing `get_data_rr/ri/br` functions.
- Sub-module `uop_sync_fifo`: generic depth/width register FIFO with flush. The FSM and decode live in the top module.

## Test plan
- Push ADD, valb_sel=0, with dst=X3, src1=X1, src2=X2 → next cycle: fmt=RR, `out_dst`.gpr=3, `out_src1`.gpr=1, `out_src2`.gpr=2, `out_imm`=0.
- Push MOVK with imm=0x1234, hw=2 → `out_imm`=0x0000_1234_0000_0000. Push ADD, valb_sel=1, imm=21'h1FFFFF → `out_imm`=all ones.
- Push BCOND with target 0x4000, cond=4'hA, predict_taken=1 → fmt=BR with those fields; `out_dst`/`out_src1`/`out_src2`=0.
- Hold `out_ready`=0 and push 3 uops → `in_ready` drops after 2 pushes. Release `out_ready` → uops drain in order, one per cycle.
- Push HLT then ADD → ADD is not accepted. Pop HLT → `halted_out`=1 next cycle. Pulse `flush_in` → `halted_out`=0 and `in_ready`=1.
- Assert `rst_N_in` low with 2 entries mid-stream → `out_valid`=0 immediately. With `UOP_UNPACK_CHECK_EN`: push opcode 5'd30 → `out_illegal`=1, then the block halts.
